// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative signed WIDTH x WIDTH multiplier and signed WIDTH / WIDTH divider
//   behind the CPU's MUL and DIV/MOD instructions. Operands are reduced to
//   unsigned magnitudes on accept. The unit then runs WIDTH cycles of either
//   shift-add multiplication or restoring division. Sign-corrected results
//   are registered together with a one-cycle done pulse.
//
// Ports
//   clk, rst       : system clock, asynchronous active-high reset
//   req_mul        : level request, current instruction is MUL (wins over DIV)
//   req_div        : level request, current instruction is DIV or MOD
//   op_a, op_b     : signed operands (CPU D and A)
//   busy           : combinational stall to the arbiter
//   mul_done       : one-cycle pulse, mul_product valid
//   div_done       : one-cycle pulse, div_quotient / div_remainder valid
//   mul_product    : signed 2*WIDTH product
//   div_quotient   : signed quotient, truncated toward zero
//   div_remainder  : signed remainder, sign of the dividend
//   div_by_zero    : last division had a zero divisor (cleared on accept)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_mul,
  input  logic                 req_div,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 mul_done,
  output logic                 div_done,
  output logic [2*WIDTH-1:0]   mul_product,
  output logic [WIDTH-1:0]     div_quotient,
  output logic [WIDTH-1:0]     div_remainder,
  output logic                 div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unsigned WIDTH+1-bit magnitude; the extra bit holds |most negative value|.
  function automatic logic [WIDTH:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    if (v[WIDTH-1]) begin
      magnitude = ~ext + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      magnitude = ext;
    end
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic                 accept_s;
  logic                 last_s;

  logic                 is_mul_r;
  logic                 neg_res_r;   // product / quotient sign
  logic                 neg_rem_r;   // remainder sign (dividend sign)
  logic                 div_zero_r;
  logic [WIDTH:0]       oper_r;      // multiplicand or divisor magnitude
  logic [WIDTH:0]       hi_r;        // partial product high / partial remainder
  logic [WIDTH-1:0]     lo_r;        // multiplier bits / dividend-quotient bits
  logic [CW-1:0]        cnt_r;

  logic [WIDTH:0]       mag_a_s;
  logic [WIDTH:0]       mag_b_s;
  logic [WIDTH:0]       add_s;
  logic [WIDTH:0]       trial_s;
  logic [WIDTH:0]       hi_s;
  logic [WIDTH-1:0]     lo_s;
  logic [2*WIDTH-1:0]   prod_mag_s;
  logic [WIDTH-1:0]     rem_mag_s;

  logic                 mul_done_r;
  logic                 div_done_r;
  logic [2*WIDTH-1:0]   mul_product_r;
  logic [WIDTH-1:0]     div_quotient_r;
  logic [WIDTH-1:0]     div_remainder_r;
  logic                 div_by_zero_r;

  // Next-state, accept strobe and stall request.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    busy     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_mul | req_div) begin
          accept_s = 1'b1;
          busy     = 1'b1;
          state_s  = CALC;
        end else begin
          state_s  = IDLE;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_r == LAST_ITER) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        // Requests are ignored here so a held request cannot retrigger.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mag_a_s = magnitude(op_a);
    mag_b_s = magnitude(op_b);
    last_s  = (state_r == CALC) && (cnt_r == LAST_ITER);
    add_s   = hi_r + oper_r;
    trial_s = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
    if (is_mul_r) begin
      // Add multiplicand when the current multiplier bit is set, then shift
      // the {high, low} pair right; low fills with finished product bits.
      if (!lo_r[0]) begin
        add_s = hi_r;
      end else begin
        add_s = hi_r + oper_r;
      end
      hi_s = {1'b0, add_s[WIDTH:1]};
      lo_s = {add_s[0], lo_r[WIDTH-1:1]};
    end else begin
      // Shift next dividend bit into the remainder and try to subtract.
      if (trial_s >= oper_r) begin
        hi_s = trial_s - oper_r;
        lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_s = trial_s;
        lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end
    prod_mag_s = {hi_s[WIDTH-1:0], lo_s};
    rem_mag_s  = hi_s[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch on accept and iteration datapath during CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_mul_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      oper_r     <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      cnt_r      <= '0;
    end else if (accept_s) begin
      is_mul_r   <= req_mul;
      neg_res_r  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_rem_r  <= op_a[WIDTH-1];
      div_zero_r <= (op_b == '0);
      hi_r       <= '0;
      cnt_r      <= '0;
      if (req_mul) begin
        oper_r <= mag_a_s;
        lo_r   <= mag_b_s[WIDTH-1:0];
      end else begin
        oper_r <= mag_b_s;
        lo_r   <= mag_a_s[WIDTH-1:0];
      end
    end else if (state_r == CALC) begin
      hi_r  <= hi_s;
      lo_r  <= lo_s;
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Result registers and done pulses, loaded on the CALC->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_done_r      <= 1'b0;
      div_done_r      <= 1'b0;
      mul_product_r   <= '0;
      div_quotient_r  <= '0;
      div_remainder_r <= '0;
      div_by_zero_r   <= 1'b0;
    end else begin
      mul_done_r <= last_s && is_mul_r;
      div_done_r <= last_s && !is_mul_r;
      if (accept_s) begin
        div_by_zero_r <= 1'b0;
      end else if (last_s && !is_mul_r) begin
        div_by_zero_r <= div_zero_r;
      end
      if (last_s && is_mul_r) begin
        // Negating a zero magnitude yields zero, so no extra guard is needed.
        mul_product_r <= neg_res_r ? -prod_mag_s : prod_mag_s;
      end
      if (last_s && !is_mul_r) begin
        // Zero divisor: restoring division already leaves |op_a| as the
        // remainder, so only the quotient needs forcing to -1.
        if (div_zero_r) begin
          div_quotient_r <= '1;
        end else begin
          div_quotient_r <= neg_res_r ? -lo_s : lo_s;
        end
        div_remainder_r <= neg_rem_r ? -rem_mag_s : rem_mag_s;
      end
    end
  end

  assign mul_done      = mul_done_r;
  assign div_done      = div_done_r;
  assign mul_product   = mul_product_r;
  assign div_quotient  = div_quotient_r;
  assign div_remainder = div_remainder_r;
  assign div_by_zero   = div_by_zero_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit: directed spec cases plus randomized
//   operations checked against plain signed integer arithmetic.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_mul;
  logic        req_div;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        mul_done;
  logic        div_done;
  logic [31:0] mul_product;
  logic [15:0] div_quotient;
  logic [15:0] div_remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_mul      (req_mul),
    .req_div      (req_div),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .mul_done     (mul_done),
    .div_done     (div_done),
    .mul_product  (mul_product),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference multiply: plain signed integer product.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return 32'(sa * sb);
  endfunction

  // Reference divide: C-style truncation, with the zero and overflow rules.
  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic dz);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      q = 16'hFFFF; r = a; dz = 1'b1;
    end else if (sa == -32768 && sb == -1) begin
      q = 16'h8000; r = 16'h0000; dz = 1'b0;
    end else begin
      q = 16'(sa / sb); r = 16'(sa % sb); dz = 1'b0;
    end
  endtask

  // Issue one request and observe a 40-cycle window. Operands are scrambled
  // after accept. The request drops at the done cycle, or one cycle later
  // when keep_req is set.
  task automatic do_op(input bit m, input bit d, input logic [15:0] a, input logic [15:0] b,
                       input bit keep_req, output int lat, output int nbusy,
                       output int nmul, output int ndiv);
    lat = -1; nbusy = 0; nmul = 0; ndiv = 0;
    @(negedge clk);
    req_mul = m; req_div = d; op_a = a; op_b = b;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy) nbusy++;
      if (mul_done) nmul++;
      if (div_done) ndiv++;
      if (lat >= 0 && c == lat + 1) begin
        req_mul = 1'b0; req_div = 1'b0;
      end
      if ((mul_done || div_done) && lat < 0) begin
        lat = c;
        if (!keep_req) begin
          req_mul = 1'b0; req_div = 1'b0;
        end
      end
      if (c >= 1 && lat < 0) begin
        op_a = 16'($urandom); op_b = 16'($urandom);
      end
      @(negedge clk);
    end
    req_mul = 1'b0; req_div = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_mul = 1'b0; req_div = 1'b0; op_a = 16'h0; op_b = 16'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, mul_done, div_done, div_by_zero} !== 4'b0000)
      $display("FAIL reset_flags got %b expected 0000", {busy, mul_done, div_done, div_by_zero});
    else n_pass++;
    n_checks++;
    if ({mul_product, div_quotient, div_remainder} !== 64'h0)
      $display("FAIL reset_data got %h expected 0", {mul_product, div_quotient, div_remainder});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_mul_directed;
    logic [15:0] ta [5] = '{16'd300,  16'h8000, 16'h0000, 16'hFFFF, 16'h7FFF};
    logic [15:0] tb [5] = '{16'hFFF9, 16'h8000, 16'hFFFB, 16'hFFFF, 16'h8000};
    logic [31:0] tp [5] = '{32'hFFFFF7CC, 32'h40000000, 32'h0, 32'h1, 32'hC0008000};
    int lat, nb, nm, nd;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, 1'b0, ta[i], tb[i], 1'b0, lat, nb, nm, nd);
      n_checks++;
      if (lat !== 17 || nb !== 17) $display("FAIL mul_latency[%0d] got lat=%0d busy=%0d expected 17/17", i, lat, nb);
      else n_pass++;
      n_checks++;
      if (nm !== 1 || nd !== 0) $display("FAIL mul_pulses[%0d] got mul=%0d div=%0d expected 1/0", i, nm, nd);
      else n_pass++;
      n_checks++;
      if (mul_product !== tp[i]) $display("FAIL mul_product[%0d] got %h expected %h", i, mul_product, tp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div_directed;
    logic [15:0] ta [7] = '{16'd7,    16'hFFF9, 16'h8000, 16'd1234, 16'hFFF9, 16'd100, 16'h8000};
    logic [15:0] tb [7] = '{16'hFFFE, 16'd2,    16'hFFFF, 16'd0,    16'd0,    16'd7,   16'd0};
    logic [15:0] tq [7] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'hFFFF, 16'hFFFF, 16'd14,  16'hFFFF};
    logic [15:0] tr [7] = '{16'd1,    16'hFFFF, 16'h0000, 16'd1234, 16'hFFF9, 16'd2,   16'h8000};
    logic        tz [7] = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,    1'b1};
    int lat, nb, nm, nd;
    for (int i = 0; i < 7; i++) begin
      do_op(1'b0, 1'b1, ta[i], tb[i], 1'b0, lat, nb, nm, nd);
      n_checks++;
      if (lat !== 17 || nb !== 17) $display("FAIL div_latency[%0d] got lat=%0d busy=%0d expected 17/17", i, lat, nb);
      else n_pass++;
      n_checks++;
      if (nm !== 0 || nd !== 1) $display("FAIL div_pulses[%0d] got mul=%0d div=%0d expected 0/1", i, nm, nd);
      else n_pass++;
      n_checks++;
      if (div_quotient !== tq[i] || div_remainder !== tr[i] || div_by_zero !== tz[i])
        $display("FAIL div_result[%0d] got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                 i, div_quotient, div_remainder, div_by_zero, tq[i], tr[i], tz[i]);
      else n_pass++;
    end
  endtask

  task automatic test_dz_clear;
    int lat, nb, nm, nd;
    n_checks++;
    if (div_by_zero !== 1'b1) $display("FAIL dz_sticky got %b expected 1", div_by_zero);
    else n_pass++;
    do_op(1'b1, 1'b0, 16'd12, 16'd5, 1'b0, lat, nb, nm, nd);
    n_checks++;
    if (div_by_zero !== 1'b0 || mul_product !== 32'd60)
      $display("FAIL dz_clear got dz=%b p=%h expected dz=0 p=0000003c", div_by_zero, mul_product);
    else n_pass++;
  endtask

  task automatic test_both_req;
    int lat, nb, nm, nd;
    do_op(1'b1, 1'b1, 16'hFF00, 16'd3, 1'b0, lat, nb, nm, nd);
    n_checks++;
    if (nm !== 1 || nd !== 0 || lat !== 17) $display("FAIL both_req got mul=%0d div=%0d lat=%0d expected 1/0/17", nm, nd, lat);
    else n_pass++;
    n_checks++;
    if (mul_product !== ref_mul(16'hFF00, 16'd3)) $display("FAIL both_req_product got %h expected %h", mul_product, ref_mul(16'hFF00, 16'd3));
    else n_pass++;
  endtask

  task automatic test_hold_req;
    int lat, nb, nm, nd;
    do_op(1'b0, 1'b1, 16'd500, 16'd9, 1'b1, lat, nb, nm, nd);
    // 17 busy cycles plus the IDLE cycle where the held request is re-seen.
    n_checks++;
    if (nd !== 1 || nm !== 0 || lat !== 17 || nb !== 18)
      $display("FAIL hold_req got div=%0d mul=%0d lat=%0d busy=%0d expected 1/0/17/18", nd, nm, lat, nb);
    else n_pass++;
    n_checks++;
    if (div_quotient !== 16'd55 || div_remainder !== 16'd5) $display("FAIL hold_req_result got q=%h r=%h expected 0037/0005", div_quotient, div_remainder);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat, nb, nm, nd, pulses;
    @(negedge clk);
    req_mul = 1'b1; op_a = 16'd300; op_b = 16'hFFF9;
    repeat (9) @(negedge clk);   // cycle 9 is CALC iteration 8
    #1;
    rst = 1'b1; req_mul = 1'b0;
    #1;
    n_checks++;
    if ({busy, mul_done, div_done, div_by_zero} !== 4'b0000 || {mul_product, div_quotient, div_remainder} !== 64'h0)
      $display("FAIL reset_mid got flags=%b data=%h expected all 0", {busy, mul_done, div_done, div_by_zero},
               {mul_product, div_quotient, div_remainder});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      if (mul_done || div_done) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 0) $display("FAIL reset_mid_pulse got %0d expected 0", pulses);
    else n_pass++;
    do_op(1'b1, 1'b0, 16'd300, 16'hFFF9, 1'b0, lat, nb, nm, nd);
    n_checks++;
    if (lat !== 17 || nb !== 17 || nm !== 1 || mul_product !== 32'hFFFFF7CC)
      $display("FAIL reissue got lat=%0d busy=%0d pulses=%0d p=%h expected 17/17/1/fffff7cc", lat, nb, nm, mul_product);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    c1 = -1; c2 = -1;
    @(negedge clk);
    req_div = 1'b1; op_a = 16'd100; op_b = 16'd7;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (div_done) begin c1 = c; break; end
      @(negedge clk);
    end
    n_checks++;
    if (c1 !== 17 || div_quotient !== 16'd14 || div_remainder !== 16'd2)
      $display("FAIL b2b_first got lat=%0d q=%h r=%h expected 17/000e/0002", c1, div_quotient, div_remainder);
    else n_pass++;
    req_div = 1'b0; req_mul = 1'b1; op_a = 16'hFED4; op_b = 16'd7;
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b expected 1", busy);
    else n_pass++;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (mul_done) begin c2 = c; break; end
    end
    req_mul = 1'b0;
    n_checks++;
    if (c2 !== 17 || mul_product !== 32'hFFFFF7CC)
      $display("FAIL b2b_second got lat=%0d p=%h expected 17/fffff7cc", c2, mul_product);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [15:0] edges [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE};
    logic [15:0] a, b, eq, er;
    logic        ez, m;
    int lat, nb, nm, nd;
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
      do_op(m, !m, a, b, 1'b0, lat, nb, nm, nd);
      n_checks++;
      if (lat !== 17 || nb !== 17 || nm !== int'(m) || nd !== int'(!m))
        $display("FAIL rand_timing[%0d] got lat=%0d busy=%0d mul=%0d div=%0d", i, lat, nb, nm, nd);
      else n_pass++;
      n_checks++;
      if (m) begin
        if (mul_product !== ref_mul(a, b) || div_by_zero !== 1'b0)
          $display("FAIL rand_mul[%0d] a=%h b=%h got %h dz=%b expected %h dz=0", i, a, b, mul_product, div_by_zero, ref_mul(a, b));
        else n_pass++;
      end else begin
        ref_div(a, b, eq, er, ez);
        if (div_quotient !== eq || div_remainder !== er || div_by_zero !== ez)
          $display("FAIL rand_div[%0d] a=%h b=%h got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                   i, a, b, div_quotient, div_remainder, div_by_zero, eq, er, ez);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_dz_clear();
    test_both_req();
    test_hold_req();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
